// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port.
//
// Takes one load/store request at a time and drives a word-aligned, byte-masked
// memory (synchronous write, combinational read). Loads are sign- or zero-extended
// according to RV32I funct3.
//
// Build option: define LSU_MISALIGN_EN to split word-crossing accesses into two
// memory cycles (ACC0 + ACC1). When it is undefined, any access whose offset is not
// a multiple of its size responds with resp_err and performs no write.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only when idle)
//   req_we, req_funct3              store/load select and RV32I size/extension code
//   req_addr, req_wdata             byte address, right-justified store data
//   resp_valid/resp_rdata/resp_err  one-cycle completion pulse with result
//   mem_addr/mem_wdata/mem_wmask    word address, lane-positioned data, byte enables
//   mem_wen, mem_rdata              write enable, combinational read data
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    output logic              mem_wen,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc0 = 2'd1,
`ifdef LSU_MISALIGN_EN
        StAcc1 = 2'd3,
`endif
        StResp = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
`ifdef LSU_MISALIGN_EN
    logic [31:0]       hi_q, hi_d;
`endif

    logic [1:0]        off;
    logic [3:0]        size_mask;
    logic [31:0]       byte_mask;
    logic              legal;
    logic              err;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       sh;
`ifdef LSU_MISALIGN_EN
    logic [7:0]        lm;
    logic [63:0]       wd;
    logic              cross;
`else
    logic [3:0]        lm;
    logic [31:0]       wd;
`endif

    // Request decode, all from latched registers so memory outputs never see req_*.
    always_comb begin
        off       = addr_q[1:0];
        base_addr = {addr_q[ADDR_W-1:2], 2'b00};
        case (funct3_q[1:0])
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        byte_mask = {{8{size_mask[3]}}, {8{size_mask[2]}}, {8{size_mask[1]}}, {8{size_mask[0]}}};
        legal = we_q ? (funct3_q <= 3'd2)
                     : (funct3_q != 3'd3 && funct3_q != 3'd6 && funct3_q != 3'd7);
`ifdef LSU_MISALIGN_EN
        lm    = {4'b0000, size_mask} << off;
        wd    = {32'b0, wdata_q & byte_mask} << {off, 3'b000};
        err   = !legal;
        cross = legal && (lm[7:4] != 4'b0000);
        sh    = 32'({hi_q, lo_q} >> {off, 3'b000});
`else
        lm    = size_mask << off;
        wd    = (wdata_q & byte_mask) << {off, 3'b000};
        // Offset must be a multiple of the size: halves need off[0]=0, words off=0.
        err   = !legal || (size_mask[1] && off[0]) || (size_mask[3] && off[1]);
        sh    = lo_q >> {off, 3'b000};
`endif
    end

    // Next state and memory-side outputs.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lo_d      = lo_q;
`ifdef LSU_MISALIGN_EN
        hi_d      = hi_q;
`endif
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        mem_wen   = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    state_d  = StAcc0;
                end
            end
            StAcc0: begin
                mem_addr = base_addr;
                if (we_q && !err) begin
                    mem_wen   = 1'b1;
                    mem_wmask = lm[3:0];
                    mem_wdata = wd[31:0];
                end
                lo_d = mem_rdata;
`ifdef LSU_MISALIGN_EN
                // Clear hi so a non-crossing load does not see a stale upper word.
                hi_d    = '0;
                state_d = cross ? StAcc1 : StResp;
`else
                state_d = StResp;
`endif
            end
`ifdef LSU_MISALIGN_EN
            StAcc1: begin
                mem_addr = base_addr + ADDR_W'(4);
                if (we_q) begin
                    mem_wen   = 1'b1;
                    mem_wmask = lm[7:4];
                    mem_wdata = wd[63:32];
                end
                hi_d    = mem_rdata;
                state_d = StResp;
            end
`endif
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Response outputs decode from state and latched registers only.
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_err   = resp_valid && err;
        resp_rdata = '0;
        if (resp_valid && !we_q && !err) begin
            case (funct3_q[1:0])
                2'd0:    resp_rdata = {{24{sh[7] & ~funct3_q[2]}}, sh[7:0]};
                2'd1:    resp_rdata = {{16{sh[15] & ~funct3_q[2]}}, sh[15:0]};
                default: resp_rdata = sh;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
`ifdef LSU_MISALIGN_EN
            hi_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
`ifdef LSU_MISALIGN_EN
            hi_q     <= hi_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_wen;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_wen    (mem_wen),
        .mem_rdata  (mem_rdata)
    );

    // Memory model: 256 words indexed by address bits [9:2].
    logic [31:0] mem [256];
    logic        tb_wen = 1'b0;
    logic [7:0]  tb_idx = '0;
    logic [31:0] tb_data = '0;
    int          wr_count = 0;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (tb_wen) begin
            mem[tb_idx] <= tb_data;
        end else if (mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            wr_count <= wr_count + 1;
        end
    end

    int n_pass = 0;
    int n_total = 0;
    int wr_before;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        tb_idx  = idx;
        tb_data = d;
        tb_wen  = 1'b1;
        step();
        tb_wen  = 1'b0;
    endtask

    // Present a request in IDLE; returns #1 after the acceptance edge (inside ACC0).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        step();
        req_valid  = 1'b0;
    endtask

    // Aligned load: no write in ACC0, result at T+2, idle at T+3.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp);
        issue(1'b0, f3, a, 32'h0);
        chk({tag, "_acc0_wen"}, 32'(mem_wen), 32'h0);
        step();
        chk({tag, "_valid"}, 32'(resp_valid), 32'h1);
        chk({tag, "_rdata"}, resp_rdata, exp);
        chk({tag, "_err"}, 32'(resp_err), 32'h0);
        step();
    endtask

    // Request that must error: no write in ACC0, err with zero data at T+2.
    task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a);
        wr_before = wr_count;
        issue(we, f3, a, 32'hFFFF_FFFF);
        chk({tag, "_acc0_wen"}, 32'(mem_wen), 32'h0);
        chk({tag, "_acc0_mask"}, 32'(mem_wmask), 32'h0);
        step();
        chk({tag, "_valid"}, 32'(resp_valid), 32'h1);
        chk({tag, "_err"}, 32'(resp_err), 32'h1);
        chk({tag, "_rdata"}, resp_rdata, 32'h0);
        step();
        chk({tag, "_nowrite"}, 32'(wr_count - wr_before), 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #12;
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'h0);
        chk("rst_maddr", mem_addr, 32'h0);
        chk("rst_mwdata", mem_wdata, 32'h0);
        chk("rst_mmask", 32'(mem_wmask), 32'h0);
        chk("rst_mwen", 32'(mem_wen), 32'h0);
        rst_n = 1'b1;
        step();

        // SW then LW aligned
        issue(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF);
        chk("sw_ready", 32'(req_ready), 32'h0);
        chk("sw_addr", mem_addr, 32'h100);
        chk("sw_wen", 32'(mem_wen), 32'h1);
        chk("sw_mask", 32'(mem_wmask), 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        chk("sw_valid", 32'(resp_valid), 32'h1);
        chk("sw_err", 32'(resp_err), 32'h0);
        chk("sw_rdata", resp_rdata, 32'h0);
        chk("sw_resp_wen", 32'(mem_wen), 32'h0);
        step();
        chk("sw_idle_ready", 32'(req_ready), 32'h1);
        chk("sw_idle_valid", 32'(resp_valid), 32'h0);
        do_load("lw", 3'd2, 32'h100, 32'hDEAD_BEEF);

        // Byte and half loads from 0x80FF7F01
        preload(8'd64, 32'h80FF_7F01);
        do_load("lb103", 3'd0, 32'h103, 32'hFFFF_FF80);
        do_load("lbu103", 3'd4, 32'h103, 32'h0000_0080);
        do_load("lb101", 3'd0, 32'h101, 32'h0000_007F);
        do_load("lh102", 3'd1, 32'h102, 32'hFFFF_80FF);
        do_load("lhu100", 3'd5, 32'h100, 32'h0000_7F01);

        // SB with upper junk in wdata, then SH
        issue(1'b1, 3'd0, 32'h102, 32'h1234_56AB);
        chk("sb_mask", 32'(mem_wmask), 32'h4);
        chk("sb_wdata", mem_wdata, 32'h00AB_0000);
        step();
        step();
        do_load("lw_after_sb", 3'd2, 32'h100, 32'h80AB_7F01);
        issue(1'b1, 3'd1, 32'h100, 32'h9876_CAFE);
        chk("sh_mask", 32'(mem_wmask), 32'h3);
        chk("sh_wdata", mem_wdata, 32'h0000_CAFE);
        step();
        step();
        do_load("lh_after_sh", 3'd1, 32'h100, 32'hFFFF_CAFE);

        // Illegal funct3
        do_err("ld_f3_3", 1'b0, 3'd3, 32'h100);
        do_err("st_f3_5", 1'b1, 3'd5, 32'h100);

        // req_valid held and changed outside IDLE must be ignored
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h100;
        step();
        req_addr   = 32'h104;
        req_funct3 = 3'd0;
        chk("hold_addr", mem_addr, 32'h100);
        step();
        chk("hold_rdata", resp_rdata, 32'h80AB_CAFE);
        req_valid = 1'b0;
        step();
        chk("hold_idle", 32'(req_ready), 32'h1);

`ifdef LSU_MISALIGN_EN
        preload(8'd65, 32'hAA00_0000);
        issue(1'b1, 3'd2, 32'h103, 32'h1122_3344);
        chk("xsw_a0_addr", mem_addr, 32'h100);
        chk("xsw_a0_mask", 32'(mem_wmask), 32'h8);
        chk("xsw_a0_data", mem_wdata, 32'h4400_0000);
        step();
        chk("xsw_a1_addr", mem_addr, 32'h104);
        chk("xsw_a1_mask", 32'(mem_wmask), 32'h7);
        chk("xsw_a1_data", mem_wdata, 32'h0011_2233);
        chk("xsw_a1_valid", 32'(resp_valid), 32'h0);
        step();
        chk("xsw_valid", 32'(resp_valid), 32'h1);
        step();
        issue(1'b0, 3'd2, 32'h103, 32'h0);
        step();
        chk("xlw_t2_valid", 32'(resp_valid), 32'h0);
        step();
        chk("xlw_valid", 32'(resp_valid), 32'h1);
        chk("xlw_rdata", resp_rdata, 32'h1122_3344);
        step();
        // Wrap: byte @0xFFFFFFFF = 0x9A, byte @0x0 = 0xB4
        preload(8'd255, 32'h9A00_0000);
        preload(8'd0, 32'h0000_00B4);
        issue(1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0);
        chk("wrap_a0_addr", mem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_a1_addr", mem_addr, 32'h0000_0000);
        step();
        chk("wrap_rdata", resp_rdata, 32'hFFFF_B49A);
        step();
`else
        do_err("sh101", 1'b1, 3'd1, 32'h101);
        do_err("lw102", 1'b0, 3'd2, 32'h102);
        chk("mis_mem_kept", mem[64], 32'h80AB_CAFE);
`endif

        // Reset during ACC0 of a store: nothing written, no response
        wr_before = wr_count;
`ifdef LSU_MISALIGN_EN
        issue(1'b1, 3'd2, 32'h107, 32'h5555_5555);
`else
        issue(1'b1, 3'd2, 32'h104, 32'h5555_5555);
`endif
        chk("mr_wen_before", 32'(mem_wen), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_wen", 32'(mem_wen), 32'h0);
        chk("mr_mask", 32'(mem_wmask), 32'h0);
        chk("mr_addr", mem_addr, 32'h0);
        chk("mr_ready", 32'(req_ready), 32'h1);
        step();
        step();
        chk("mr_valid", 32'(resp_valid), 32'h0);
        rst_n = 1'b1;
        step();
        chk("mr_ready_after", 32'(req_ready), 32'h1);
        chk("mr_valid_after", 32'(resp_valid), 32'h0);
        chk("mr_nowrite", 32'(wr_count - wr_before), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port. Accepts one load/store request at a time from the execute stage and drives the data memory's word-aligned, byte-masked interface (synchronous write, asynchronous read). Generates byte lanes and write masks, and splits word-crossing accesses into two memory cycles. Returns load data sign- or zero-extended per RV32I `funct3`.

## Interface
Parameters:
- `ADDR_W`, 32, request and memory address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; the request is accepted on `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse, for loads and stores.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: qualifies `resp_valid`; set for an illegal `funct3`, or a misaligned access when splitting is compiled out.
- `mem_addr` out ADDR_W: word-aligned address, bits [1:0] always 00.
- `mem_wdata` out 32: lane-positioned write data.
- `mem_wmask` out 4: byte write enables.
- `mem_wen` out 1: write enable.
- `mem_rdata` in 32: combinational read data for `mem_addr`.

## Operation
States are IDLE, ACC0, ACC1, RESP.

- **Accept.** On acceptance, latch `we`, `funct3`, `addr`, `wdata`.
  - Offset `o = addr[1:0]`.
  - Size `n` = 1, 2 or 4 bytes.
  - `cross = (o + n > 4)`.
- **Lane arithmetic.** Computed over 8 bytes.
  - Lane mask: `lm[7:0] = ((1<<n)-1) << o`.
  - Store data: `wd[63:0] = {32'b0, wdata masked to n bytes} << (8*o)`.
  - ACC0 uses `lm[3:0]`/`wd[31:0]`; ACC1 uses `lm[7:4]`/`wd[63:32]`.
- **ACC0.**
  - Drive `mem_addr = {addr[ADDR_W-1:2], 2'b00}`.
  - Store: `mem_wen = 1`, `mem_wmask = lm[3:0]`.
  - Load: `mem_wen = 0`, `mem_wmask = 0`; capture `mem_rdata` into `lo` at the edge.
  - Next state: ACC1 if `cross`, else RESP.
- **ACC1.**
  - Drive `mem_addr` = ACC0 address + 4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x00000000).
  - Store uses the upper lanes; load captures `hi`. Next state is RESP.
- **Load result.**
  - `sh = {hi, lo} >> (8*o)`; take `sh[8n-1:0]`.
  - Sign-extend for LB and LH; zero-extend for LBU, LHU and LW.
  - Non-crossing loads use `hi = 0`.
- **RESP.** `resp_valid = 1` with `resp_rdata` and `resp_err` registered. Next state is IDLE. There is no response backpressure.
- **Illegal `funct3`** (loads 3/6/7, stores 3–7):
  - Still passes through ACC0, with `mem_wen = 0` and `mem_wmask = 0`.
  - Responds with `resp_err = 1` and `resp_rdata = 0`.
- **Memory outputs outside ACC0/ACC1.** `mem_wen`, `mem_wmask`, `mem_wdata` and `mem_addr` are 0 in IDLE and RESP.

## Timing
- **Reset values.** All outputs 0 except `req_ready`, which is 1 (IDLE). State is IDLE; `lo` and `hi` are cleared.
- **Latency, from the acceptance edge T.**
  - Non-crossing access: ACC0 during T+1; `resp_valid` high during T+2.
  - Crossing access: ACC1 during T+2; `resp_valid` high during T+3.
- **Back-to-back requests.** `req_ready` returns to 1 the cycle after RESP. The minimum request spacing is 3 cycles aligned, 4 cycles crossing.
- **Memory outputs.** Driven from latched registers and state only, never combinationally from `req_*`. Writes commit at the rising edge ending ACC0 (and ACC1).
- **Reset mid-operation.** Asynchronously return to IDLE. No response is produced, and no further writes occur. A write already committed at a prior edge stays committed.
- **`req_valid` outside IDLE.** Ignored; the request is not latched.

## Configuration
- **`LSU_MISALIGN_EN` defined.** Crossing accesses are split into ACC0 + ACC1 as above.
- **`LSU_MISALIGN_EN` undefined.**
  - Any access with `o` not a multiple of `n` goes through ACC0 with `mem_wen = 0` and `mem_wmask = 0`.
  - It responds at T+2 with `resp_err = 1` and `resp_rdata = 0`.
  - The ACC1 state and the `hi` register are not built.
  - Aligned accesses behave identically in both builds.

## Test plan
- **SW then LW aligned.** SW `0xDEADBEEF` @0x100 → ACC0: `mem_wmask = 1111`, `mem_wdata = 0xDEADBEEF`. Then LW @0x100 → `resp_rdata = 0xDEADBEEF` at T+2, `resp_err = 0`.
- **Byte loads and store.** With word 0x100 = `0x80FF7F01`:
  - LB @0x103 → `0xFFFFFF80`.
  - LBU @0x103 → `0x00000080`.
  - LB @0x101 → `0x0000007F`.
  - SB `0xAB` @0x102 → `mem_wmask = 0100`, `mem_wdata = 0x00AB0000`.
- **Crossing access (`LSU_MISALIGN_EN`).**
  - SW `0x11223344` @0x103 → ACC0 @0x100, mask `1000`, data `0x44000000`; ACC1 @0x104, mask `0111`, data `0x00112233`.
  - LW @0x103 then returns `0x11223344` at T+3.
- **Wrap-around (`LSU_MISALIGN_EN`).** LH @0xFFFFFFFF → ACC1 `mem_addr = 0x00000000`. Result = `{byte @0x0, byte @0xFFFFFFFF}` sign-extended.
- **Errors.**
  - Without `LSU_MISALIGN_EN`: SH @0x101 → no write, `resp_err = 1`, `resp_rdata = 0` at T+2.
  - Either build: load with `funct3 = 3` → `resp_err = 1`.
- **Reset mid-operation.** Assert `rst_n = 0` during ACC0 of a crossing SW. Outputs go to reset values immediately, the ACC1 write never occurs, there is no `resp_valid`, and `req_ready = 1` after release.
